fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
- Write-side controller for the async FIFO's dual-port RAM, running entirely in the wr_clk domain.
- Converts push requests into the RAM's write_enable and write_addr.
- Keeps the binary and Gray write pointers and double-flop synchronises the read-domain Gray pointer.
- Produces wr_full, wr_almost_full, a fill level and a sticky overflow flag; wr_full also drives the RAM's wr_full input.

Parameters:
ADDR_WIDTH, 5, RAM address width (must be >= 2); depth DEPTH = 2^ADDR_WIDTH
ALMOST_FULL_THRESH, 28, fill level at which wr_almost_full asserts (legal range 1..DEPTH)

Ports:
wr_clk  input  1  write-domain clock; rising edge
wr_rst_n  input  1  reset, asynchronous, active-low
wr_req  input  1  push request; data is presented to the RAM in the same cycle
rd_gray_ptr  input  ADDR_WIDTH+1  read pointer in Gray code, from the read domain (asynchronous to wr_clk)
ovf_clr  input  1  clears wr_overflow
write_enable  output  1  RAM write strobe
write_addr  output  ADDR_WIDTH  RAM write address
wr_gray_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchroniser
wr_full  output  1  FIFO full (registered)
wr_almost_full  output  1  level >= ALMOST_FULL_THRESH (registered)
wr_level  output  ADDR_WIDTH+1  fill level 0..DEPTH as seen from the write domain (registered)
wr_overflow  output  1  sticky: a push was attempted while full

Behaviour:
- Reset (wr_rst_n=0, asynchronous, no clock needed): wr_bin, wr_gray_ptr, sync flops rq1/rq2, wr_full, wr_almost_full, wr_level and wr_overflow all go to 0; write_addr=0.
- write_enable = wr_req & ~wr_full, combinational, with no extra latency.
- write_addr = wr_bin[ADDR_WIDTH-1:0].
- Next pointer: wr_bin_nxt = wr_bin + write_enable, modulo 2^(ADDR_WIDTH+1), so it wraps naturally. wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1). Both are registered every edge.
- Synchroniser: rq1 <= rd_gray_ptr; rq2 <= rq1. A read-domain change is visible in rq2 after 2 wr_clk edges.
- Full: wr_full <= (wr_gray_nxt == {~rq2[A:A-1], rq2[A-2:0]}), where A = ADDR_WIDTH.
  - wr_full asserts on the same edge that performs the DEPTH-th outstanding write.
  - It deasserts on the 3rd edge after rd_gray_ptr advances (2 sync edges + 1 flag edge).
- Level: rd_bin_s = Gray-to-binary(rq2); wr_level <= wr_bin_nxt - rd_bin_s, modulo 2^(A+1).
  - The value is pessimistic: reads not yet synchronised count as still occupied.
  - It never exceeds DEPTH during legal operation.
- wr_almost_full <= (wr_bin_nxt - rd_bin_s) >= ALMOST_FULL_THRESH, registered in the same cycle as wr_level.
- Overflow: on an edge with wr_req & wr_full, wr_overflow <= 1. It holds until an edge with ovf_clr=1 and no new overflow. A simultaneous set and clear resolves as set.
- Push while full: no RAM write, and pointers, level and Gray output are unchanged.
- wr_req is ignored while wr_rst_n=0.
- Reset mid-operation: all state clears immediately and the pointers restart at 0. The system resets the read domain concurrently; the block does not handshake the reset.
- Only wr_gray_ptr leaves the domain. It changes at most one bit per edge, and it is a flop output with no combinational path.

Test Plan:
1. Reset: wr_rst_n=0 with wr_req=1 and rd_gray_ptr=6'b000101 -> all outputs 0, write_enable=0; after release, no state change until wr_req is sampled.
2. Fill from empty: rd_gray_ptr=0, wr_req=1 for 32 cycles ->
   - write_addr steps 0..31 and write_enable is high for each.
   - wr_almost_full rises on the 28th write edge (wr_level=28).
   - wr_full rises on the 32nd write edge; wr_level=32, wr_gray_ptr=6'b110000.
3. Overflow: in the full state, hold wr_req=1 for 3 cycles ->
   - write_enable=0 and write_addr stays 0.
   - wr_overflow=1 after the first such edge.
   - A 1-cycle ovf_clr pulse with wr_req=0 clears it; ovf_clr together with wr_req at full keeps it at 1.
4. Sync latency: from full, change rd_gray_ptr to 6'b000001 ->
   - wr_full stays 1 for 2 edges and drops on the 3rd.
   - On that edge wr_level=31 and wr_almost_full stays 1.
5. Wrap-around: the read side follows with rd_gray_ptr = Gray(writes-4); do 70 writes ->
   - write_addr wraps 31->0 twice.
   - wr_gray_ptr MSB toggles at the 32nd and 64th writes.
   - Exactly one bit of wr_gray_ptr changes per write, and wr_full never asserts.
6. Async reset mid-fill: after 10 writes, drop wr_rst_n between clock edges -> wr_level, write_addr and wr_gray_ptr are 0 before the next edge; refilling restarts at address 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write side: push -> RAM strobe/address, Gray pointer export, 2-flop read-pointer sync, full/level flags.
// write_enable is combinational from wr_req; flags register one edge later; pushes while full are dropped and flagged.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH         = 5,
  parameter int ALMOST_FULL_THRESH = 28
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr,
  input  logic                  ovf_clr,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_nxt;
  logic [PW-1:0] wr_gray_nxt;
  logic [PW-1:0] rq1;
  logic [PW-1:0] rq2;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_nxt;

  // Gated by reset so a request held during reset never reaches the RAM.
  assign write_enable = wr_req & ~wr_full & wr_rst_n;
  assign write_addr   = wr_bin[ADDR_WIDTH-1:0];

  assign wr_bin_nxt  = wr_bin + {{ADDR_WIDTH{1'b0}}, write_enable};
  assign wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1);

  always_comb begin
    rd_bin_s = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin_s[i] = ^(rq2 >> i);
    end
  end

  // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
  assign full_cmp  = {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]};
  assign level_nxt = wr_bin_nxt - rd_bin_s;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin         <= '0;
      wr_gray_ptr    <= '0;
      rq1            <= '0;
      rq2            <= '0;
      wr_full        <= 1'b0;
      wr_almost_full <= 1'b0;
      wr_level       <= '0;
      wr_overflow    <= 1'b0;
    end else begin
      wr_bin         <= wr_bin_nxt;
      wr_gray_ptr    <= wr_gray_nxt;
      rq1            <= rd_gray_ptr;
      rq2            <= rq1;
      wr_full        <= (wr_gray_nxt == full_cmp);
      wr_almost_full <= (level_nxt >= AF_THRESH);
      wr_level       <= level_nxt;
      if (wr_req && wr_full) begin
        wr_overflow <= 1'b1;
      end else if (ovf_clr) begin
        wr_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: reset, fill, overflow, sync latency, wrap-around and async reset.
module tb_fifo_wr_ctrl;

  logic       wr_clk;
  logic       wr_rst_n;
  logic       wr_req;
  logic [5:0] rd_gray_ptr;
  logic       ovf_clr;
  logic       write_enable;
  logic [4:0] write_addr;
  logic [5:0] wr_gray_ptr;
  logic       wr_full;
  logic       wr_almost_full;
  logic [5:0] wr_level;
  logic       wr_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  fifo_wr_ctrl #(.ADDR_WIDTH(5), .ALMOST_FULL_THRESH(28)) dut (
    .wr_clk         (wr_clk),
    .wr_rst_n       (wr_rst_n),
    .wr_req         (wr_req),
    .rd_gray_ptr    (rd_gray_ptr),
    .ovf_clr        (ovf_clr),
    .write_enable   (write_enable),
    .write_addr     (write_addr),
    .wr_gray_ptr    (wr_gray_ptr),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       req;
    logic       clr;
    logic [5:0] rd;
    logic       we;
    logic [4:0] addr;
    logic       full;
    logic       af;
    logic [5:0] level;
    logic       ovf;
    logic [5:0] gray;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [5:0] g(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; combinational outputs are
  // checked mid-cycle, registered outputs just after the next edge.
  task automatic apply_vec(input vec_t v, input int idx);
    wr_req      = v.req;
    ovf_clr     = v.clr;
    rd_gray_ptr = v.rd;
    #1;
    chk($sformatf("vec%0d.we", idx), 32'(write_enable), 32'(v.we));
    chk($sformatf("vec%0d.addr", idx), 32'(write_addr), 32'(v.addr));
    @(posedge wr_clk);
    #1;
    chk($sformatf("vec%0d.full", idx), 32'(wr_full), 32'(v.full));
    chk($sformatf("vec%0d.af", idx), 32'(wr_almost_full), 32'(v.af));
    chk($sformatf("vec%0d.level", idx), 32'(wr_level), 32'(v.level));
    chk($sformatf("vec%0d.ovf", idx), 32'(wr_overflow), 32'(v.ovf));
    chk($sformatf("vec%0d.gray", idx), 32'(wr_gray_ptr), 32'(v.gray));
  endtask

  task automatic do_reset();
    wr_rst_n    = 1'b0;
    wr_req      = 1'b0;
    ovf_clr     = 1'b0;
    rd_gray_ptr = '0;
    @(negedge wr_clk);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] prev_gray;
    logic [5:0] rd_cnt;
    int         exp_level;

    //              req   clr   rd        we    addr   full  af    lvl  ovf   gray
    vecs[0] = '{1'b1, 1'b0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b1, 6'b110000};
    vecs[1] = '{1'b1, 1'b0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b1, 6'b110000};
    vecs[2] = '{1'b1, 1'b0, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b1, 6'b110000};
    vecs[3] = '{1'b0, 1'b1, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b0, 6'b110000};
    vecs[4] = '{1'b1, 1'b1, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b1, 6'b110000};
    vecs[5] = '{1'b0, 1'b1, 6'd0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b0, 6'b110000};
    vecs[6] = '{1'b0, 1'b0, 6'd1, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b0, 6'b110000};
    vecs[7] = '{1'b0, 1'b0, 6'd1, 1'b0, 5'd0, 1'b1, 1'b1, 6'd32, 1'b0, 6'b110000};
    vecs[8] = '{1'b0, 1'b0, 6'd1, 1'b0, 5'd0, 1'b0, 1'b1, 6'd31, 1'b0, 6'b110000};
    vecs[9] = '{1'b1, 1'b0, 6'd1, 1'b1, 5'd0, 1'b1, 1'b1, 6'd32, 1'b0, 6'b110001};

    // Reset with a pending request and a nonzero read pointer.
    wr_rst_n    = 1'b0;
    wr_req      = 1'b1;
    ovf_clr     = 1'b0;
    rd_gray_ptr = 6'b000101;
    repeat (2) @(posedge wr_clk);
    #1;
    chk("rst.we", 32'(write_enable), 32'd0);
    chk("rst.addr", 32'(write_addr), 32'd0);
    chk("rst.gray", 32'(wr_gray_ptr), 32'd0);
    chk("rst.full", 32'(wr_full), 32'd0);
    chk("rst.af", 32'(wr_almost_full), 32'd0);
    chk("rst.level", 32'(wr_level), 32'd0);
    chk("rst.ovf", 32'(wr_overflow), 32'd0);
    rd_gray_ptr = '0;
    wr_req      = 1'b0;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    repeat (2) @(posedge wr_clk);
    #1;
    chk("idle.addr", 32'(write_addr), 32'd0);
    chk("idle.gray", 32'(wr_gray_ptr), 32'd0);
    chk("idle.level", 32'(wr_level), 32'd0);
    chk("idle.full", 32'(wr_full), 32'd0);

    // Fill from empty with the read side parked at 0.
    for (int k = 1; k <= 32; k++) begin
      wr_req = 1'b1;
      #1;
      chk($sformatf("fill%0d.we", k), 32'(write_enable), 32'd1);
      chk($sformatf("fill%0d.addr", k), 32'(write_addr), 32'(k - 1));
      @(posedge wr_clk);
      #1;
      chk($sformatf("fill%0d.level", k), 32'(wr_level), 32'(k));
      chk($sformatf("fill%0d.af", k), 32'(wr_almost_full), 32'(k >= 28));
      chk($sformatf("fill%0d.full", k), 32'(wr_full), 32'(k == 32));
      chk($sformatf("fill%0d.gray", k), 32'(wr_gray_ptr), 32'(g(6'(k))));
    end

    // Overflow, clear priority, sync latency, refill-to-full.
    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i], i);
    end

    // Wrap-around with the read side trailing four writes behind.
    do_reset();
    prev_gray = '0;
    for (int n = 1; n <= 70; n++) begin
      rd_cnt      = (n - 1 >= 4) ? 6'(n - 5) : 6'd0;
      rd_gray_ptr = g(rd_cnt);
      wr_req      = 1'b1;
      #1;
      chk($sformatf("wrap%0d.we", n), 32'(write_enable), 32'd1);
      chk($sformatf("wrap%0d.addr", n), 32'(write_addr), 32'((n - 1) % 32));
      @(posedge wr_clk);
      #1;
      exp_level = (n < 7) ? n : 7;
      chk($sformatf("wrap%0d.gray", n), 32'(wr_gray_ptr), 32'(g(6'(n))));
      chk($sformatf("wrap%0d.onebit", n), 32'($countones(wr_gray_ptr ^ prev_gray)), 32'd1);
      chk($sformatf("wrap%0d.msb", n), 32'(wr_gray_ptr[5] != prev_gray[5]), 32'(n % 32 == 0));
      chk($sformatf("wrap%0d.full", n), 32'(wr_full), 32'd0);
      chk($sformatf("wrap%0d.level", n), 32'(wr_level), 32'(exp_level));
      prev_gray = wr_gray_ptr;
    end

    // Asynchronous reset between edges after 10 writes.
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      wr_req = 1'b1;
      @(posedge wr_clk);
      #1;
    end
    chk("amid.level_before", 32'(wr_level), 32'd10);
    chk("amid.addr_before", 32'(write_addr), 32'd10);
    #2;
    wr_rst_n = 1'b0;
    #1;
    chk("amid.level", 32'(wr_level), 32'd0);
    chk("amid.addr", 32'(write_addr), 32'd0);
    chk("amid.gray", 32'(wr_gray_ptr), 32'd0);
    chk("amid.we", 32'(write_enable), 32'd0);
    wr_req = 1'b0;
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
    wr_req = 1'b1;
    #1;
    chk("refill.we", 32'(write_enable), 32'd1);
    chk("refill.addr", 32'(write_addr), 32'd0);
    @(posedge wr_clk);
    #1;
    chk("refill.gray", 32'(wr_gray_ptr), 32'd1);
    chk("refill.level", 32'(wr_level), 32'd1);
    chk("refill.addr1", 32'(write_addr), 32'd1);
    wr_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
